// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
// Shared definitions for the data-memory responder slice.
//   DataBus / DataAddrBus      : 32-bit data and byte-address types
//   ChipEnable/ChipDisable     : ce levels
//   WriteEnable/WriteDisable   : we levels (store / load)
//   RspIdle/RspWait/RspDone    : 2-bit responder state codes
//   DataMemNumLog2             : default log2 of the word count
//   access_err()               : range / alignment check, used only when
//                                MEM_ADDR_CHECK_EN is defined
package data_mem_responder_pkg;

    typedef logic [31:0] DataBus;
    typedef logic [31:0] DataAddrBus;

    localparam logic ChipEnable   = 1'b1;
    localparam logic ChipDisable  = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [1:0] RspIdle = 2'd0;
    localparam logic [1:0] RspWait = 2'd1;
    localparam logic [1:0] RspDone = 2'd2;

    localparam int DataMemNumLog2 = 17;

    typedef enum logic [1:0] {
        ST_IDLE = RspIdle,
        ST_WAIT = RspWait,
        ST_DONE = RspDone
    } rsp_state_t;

    // An access is bad if it reaches past the array or if its byte offset
    // does not fit the lane pattern of a word or halfword access.
    function automatic logic access_err(input DataAddrBus a, input logic [3:0] s,
                                        input int depth_log2);
        logic out_of_range;
        logic misaligned;
        out_of_range = ((a >> (depth_log2 + 2)) != '0);
        misaligned   = ((s == 4'b1111) && (a[1:0] != 2'b00)) ||
                       (((s == 4'b1100) || (s == 4'b0011)) && a[0]);
        return out_of_range || misaligned;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// CPU load/store port bundle.
//   ce, we, addr, sel, data_i : request from the CPU (master drives)
//   data_o                    : registered load data
//   stallreq_o                : pipeline stall request
//   err_o                     : access error pulse
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic       ce;
    logic       we;
    DataAddrBus addr;
    logic [3:0] sel;
    DataBus     data_i;
    DataBus     data_o;
    logic       stallreq_o;
    logic       err_o;

    modport master (output ce, we, addr, sel, data_i,
                    input  data_o, stallreq_o, err_o);
    modport slave  (input  ce, we, addr, sel, data_i,
                    output data_o, stallreq_o, err_o);
endinterface

// File: rtl/data_mem_responder_mem_array.sv
// data_mem_array
// Word array built from four byte-lane arrays so each lane has its own
// write enable. Synchronous write, combinational read. Contents are never
// cleared.
//   clk        : clock
//   i_lane_we  : per-lane write enable, bit n -> bits [8n+7:8n]
//   i_addr     : word index
//   i_wdata    : write data
//   o_rdata    : read data at i_addr
module data_mem_array #(
    parameter int DEPTH_LOG2 = 17
) (
    input  logic                  clk,
    input  logic [3:0]            i_lane_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int Depth = 1 << DEPTH_LOG2;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [Depth];

            always_ff @(posedge clk) begin
                if (i_lane_we[gi]) begin
                    r_mem[i_addr] <= i_wdata[8*gi +: 8];
                end
            end

            assign o_rdata[8*gi +: 8] = r_mem[i_addr];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-cycle data-memory responder for the CPU load/store port. Each
// request is latched in IDLE, held for WAIT_CYCLES wait states while the
// CPU is stalled, and completes on the edge into DONE (store written /
// load data registered). Optional build macro: MEM_ADDR_CHECK_EN enables
// range and alignment checking with an err_o pulse in DONE.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of data_mem_responder_if
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES    = 2,
    parameter int MEM_DEPTH_LOG2 = DataMemNumLog2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    rsp_state_t r_state;
    rsp_state_t w_state_next;
    logic [3:0] r_cnt;
    logic       r_we;
    DataAddrBus r_addr;
    logic [3:0] r_sel;
    DataBus     r_data;
    DataBus     r_data_o;
    logic       w_stall;
    logic       w_finish;
    logic       w_err;
    logic [3:0] w_lane_we;
    DataBus     w_rdata;
    DataBus     w_mask;

    // Last wait state: the access completes on this clock edge.
    assign w_finish = (r_state == ST_WAIT) && (r_cnt == 4'd0);

`ifdef MEM_ADDR_CHECK_EN
    logic r_err;
    assign w_err = access_err(r_addr, r_sel, MEM_DEPTH_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_finish && w_err;
        end
    end

    assign bus.err_o = r_err;
`else
    // Upper address bits alias and the offset bits are unchecked.
    logic w_unused_addr;
    assign w_unused_addr = ^{r_addr[31:MEM_DEPTH_LOG2+2], r_addr[1:0]};
    assign w_err         = 1'b0;
    assign bus.err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = (bus.ce == ChipEnable) ? ST_WAIT : ST_IDLE;
            ST_WAIT: w_state_next = (r_cnt == 4'd0) ? ST_DONE : ST_WAIT;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: stall from the request cycle through the last wait state.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE: w_stall = (bus.ce == ChipEnable);
            ST_WAIT: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign bus.stallreq_o = w_stall;

    // Request latch, wait counter and load-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_we     <= WriteDisable;
            r_addr   <= '0;
            r_sel    <= 4'b0000;
            r_data   <= '0;
            r_data_o <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (bus.ce == ChipEnable)) begin
                r_we   <= bus.we;
                r_addr <= bus.addr;
                r_sel  <= bus.sel;
                r_data <= bus.data_i;
                r_cnt  <= 4'(WAIT_CYCLES - 1);
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_finish && (r_we == WriteDisable)) begin
                r_data_o <= w_err ? '0 : (w_rdata & w_mask);
            end
        end
    end

    assign bus.data_o = r_data_o;

    // Expand the latched lane enables into a bit mask for loads.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign w_mask[8*gi +: 8] = {8{r_sel[gi]}};
        end
    endgenerate

    // Stores commit on the edge into DONE, so reset in WAIT writes nothing.
    assign w_lane_we = (w_finish && (r_we == WriteEnable) && !w_err) ? r_sel : 4'b0000;

    data_mem_array #(
        .DEPTH_LOG2 (MEM_DEPTH_LOG2)
    ) u_array (
        .clk       (clk),
        .i_lane_we (w_lane_we),
        .i_addr    (r_addr[MEM_DEPTH_LOG2+1:2]),
        .i_wdata   (r_data),
        .o_rdata   (w_rdata)
    );

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory responder for the CPU's load/store port (ce/we/addr/sel/data).
- Replaces the zero-wait data RAM in the SOPC when slower memory timing must be modelled.
- Holds a word array with byte-lane writes.
- Inserts WAIT_CYCLES wait states per access and raises stallreq_o so the CPU pipeline freezes until the access completes.

Parameters:
WAIT_CYCLES, 2, wait states per access; legal range 1..15.
MEM_DEPTH_LOG2, 17, log2 of word count; the array holds 2**MEM_DEPTH_LOG2 32-bit words.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
ce  input  1  chip enable; a request is present while high
we  input  1  1 = store, 0 = load; sampled with ce
addr  input  32  byte address; word index = addr[MEM_DEPTH_LOG2+1:2]
sel  input  4  byte-lane enables, big-endian: sel[3] -> data[31:24] = byte offset 0
data_i  input  32  store data
data_o  output  32  load data, registered
stallreq_o  output  1  CPU stall request
err_o  output  1  access error pulse (only with MEM_ADDR_CHECK_EN; tied 0 otherwise)

Behaviour:
- Reset values: state=IDLE, wait counter=0, data_o=0, stallreq_o=0, err_o=0. Memory contents are not cleared. Reset asserted mid-access aborts the access with no write performed.
- States: IDLE, WAIT, DONE.
- IDLE with ce=1:
  - latch we, addr, sel, data_i into request registers;
  - counter <= WAIT_CYCLES-1;
  - go to WAIT;
  - stallreq_o = 1 combinationally in this same cycle (stallreq_o = (IDLE & ce) | WAIT).
- IDLE with ce=0: stay; stallreq_o=0; data_o holds its last value.
- WAIT:
  - stallreq_o=1;
  - counter decrements each cycle; at counter==0, go to DONE;
  - ce, addr and other inputs are ignored here because the latched copies are used.
  - If ce drops in WAIT (pipeline flush), finish the access anyway. Stores must not be lost.
- DONE, for one cycle:
  - stallreq_o=0;
  - store: write latched data bytes where latched sel bit = 1 at the rising edge entering DONE, so the data is visible from the DONE cycle on;
  - load: data_o is registered at the edge entering DONE with the full word, masked by latched sel (unselected lanes read 0);
  - next state IDLE unconditionally. A new ce in the cycle after DONE is a new request.
- Total stall = WAIT_CYCLES+1 cycles; the CPU sees valid data_o during the first unstalled cycle (DONE).
- sel=0000 with ce=1: full handshake, no bytes written, data_o=0.
- Back-to-back requests: at least one IDLE cycle separates accesses. Throughput is one access per WAIT_CYCLES+2 cycles.
- Address bits above MEM_DEPTH_LOG2+1 are ignored (aliasing) unless the optional feature is enabled.

Optional Feature:
Macro MEM_ADDR_CHECK_EN.
- Defined:
  - access is out of range if any addr bit above MEM_DEPTH_LOG2+1 is 1, or addr[1:0] is inconsistent with sel (word: sel=1111 needs addr[1:0]=00; halfword: sel=1100/0011 needs addr[0]=0);
  - an erroneous store is suppressed, and an erroneous load returns 0;
  - err_o pulses 1 during the DONE cycle; timing is otherwise unchanged.
- Undefined: err_o tied 0, aliasing as above, no alignment checks.

Decomposition:
- Shared defines file:
  - existing DataBus, DataAddrBus, ChipEnable/ChipDisable, WriteEnable/WriteDisable;
  - new constants RspIdle/RspWait/RspDone (2-bit state codes);
  - new DataMemNumLog2 default.
- One natural sub-module, data_mem_array: word array with 4 byte-lane write enables, synchronous write, combinational read. The responder owns the FSM, counter, request latch and data_o register.

Test Plan:
- Reset mid-WAIT: store to 0x10, assert rst in WAIT -> stallreq_o=0, data_o=0, a later load of 0x10 returns the previous value (store aborted).
- Word store then load, WAIT_CYCLES=2: store 0x12345678 to 0x00000040, sel=1111 -> stallreq_o high 3 cycles, low in DONE. Load of 0x40 -> data_o=0x12345678 in DONE, after 3 stall cycles.
- Byte lanes: preload 0xAABBCCDD at 0x44; store 0x00000011 sel=0001 -> load returns 0xAABBCC11. Load sel=1000 -> data_o=0xAA000000.
- ce dropped in WAIT: store 0xCAFEF00D to 0x48, deassert ce after the IDLE cycle -> write still completes; later load returns 0xCAFEF00D.
- WAIT_CYCLES=1 back-to-back: two loads with ce held high -> stall pattern 1,1,0,1,1,0; data_o correct in each DONE.
- MEM_ADDR_CHECK_EN: store sel=1111 to 0x42 -> err_o=1 in DONE, memory unchanged. Store to address 0x00080000 with MEM_DEPTH_LOG2=17 -> err_o=1, write suppressed, word 0 unchanged.
